fpred_pipe: RTL
===============

# fpred_pipe

Parametrised, pipelined floating-point predicate and compare unit. It generalises the single-cycle zero/positive/negative tests to arbitrary exponent/mantissa widths and adds the following: selectable signed-zero semantics, NaN/infinity awareness, two-operand compares, an fclass-style class mask, an invalid-operation flag, and valid/ready flow control. It sits beside the FPU arithmetic units and feeds branch and compare results back to the core.

## Interface
- EXP_W, 8, exponent width; W = 1+EXP_W+MAN_W is derived.
- MAN_W, 23, mantissa (fraction) width.
- ZERO_MODE, 1, selects signed-zero semantics for the unary predicates:
  - 1: ±0 are both zero.
  - 0: legacy behaviour. Only +0 is zero, and -0 is neither zero, positive nor negative.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous and active-high.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept the request this cycle.
- in_op  in  3  operation: 0 ZERO(a), 1 POS(a), 2 NEG(a), 3 EQ(a,b), 4 LT(a,b), 5 LE(a,b), 6 CLASS(a), 7 reserved.
- in_a, in_b  in  W  operands; in_b is ignored for unary ops.
- in_tag  in  4  opaque ID, returned unchanged.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_y  out  1  predicate/compare result.
- out_class  out  10  class mask of a. Valid for every op, not only CLASS.
- out_nv  out  1  invalid-operation flag for this result.
- out_tag  out  4  tag of this result.
- nv_sticky  out  1  OR of out_nv over all accepted results since reset/clear.
- flag_clr  in  1  clears nv_sticky.

## Operation
- Field decode: sign = MSB, exp = next EXP_W bits, man = low MAN_W bits.
  - zero: exp=0, man=0.
  - subnormal: exp=0, man≠0.
  - inf: exp all-ones, man=0.
  - NaN: exp all-ones, man≠0.
  - sNaN: NaN with man MSB = 0; qNaN: NaN with man MSB = 1.
- out_class is one-hot:
  - bit0 -inf, bit1 -normal, bit2 -subnormal, bit3 -0
  - bit4 +0, bit5 +subnormal, bit6 +normal, bit7 +inf
  - bit8 sNaN, bit9 qNaN
- ZERO: 1 if a is zero, subject to ZERO_MODE.
- POS: 1 if sign=0, a is not zero and not NaN.
- NEG: 1 if sign=1, a is not NaN, and either a is not zero or… more precisely:
  - ZERO_MODE=0: NEG is 1 if sign=1 and {exp,man}≠0.
  - ZERO_MODE=1: NEG is 1 if sign=1 and a is not zero.
  - NaN always gives 0 for ZERO/POS/NEG.
- EQ, LT, LE are IEEE-754 ordered compares regardless of ZERO_MODE:
  - +0 and -0 are equal.
  - Any NaN operand forces out_y=0.
- out_nv:
  - EQ: 1 if either operand is sNaN.
  - LT/LE: 1 if either operand is any NaN.
  - CLASS/ZERO/POS/NEG: always 0.
  - op 7: out_y=0, out_nv=1.
- CLASS: out_y=0.
- nv_sticky:
  - Set on the cycle a result with out_nv=1 is accepted (out_valid & out_ready).
  - flag_clr clears it; if a set and flag_clr occur in the same cycle, the set wins.

## Timing
- Two registered stages:
  - S1: decode both operands, sign-magnitude compare on {exp,man}.
  - S2: op mux and flag generation; the S2 registers drive the outputs.
- Latency is 2 cycles from acceptance (in_valid & in_ready) to out_valid when out_ready is held high. Throughput is 1 per cycle.
- Stage advance conditions:
  - adv2 = ~s2_valid | out_ready.
  - adv1 = ~s1_valid | adv2.
  - in_ready = adv1 & ~rst.
  - The out_ready→in_ready path is combinational; no bubble is inserted under continuous flow.
- Backpressure: while out_valid & ~out_ready, out_y, out_class, out_nv and out_tag hold stable. At most 2 requests are in flight. Results leave in acceptance order.
- Reset: all of the following are 0 on the cycle after rst is sampled high, and in_ready=0 while rst=1:
  - s1_valid, s2_valid, out_valid, out_y, out_class, out_nv, out_tag, nv_sticky.
- Reset mid-flight discards in-flight requests with no output. The first request after rst falls is accepted normally.
- in_* are sampled only on acceptance. Changing them while in_ready=0 has no effect.

## Test plan
- Defaults, ZERO(0x80000000), ZERO_MODE=1 → out_y=1, out_class=0x008, result 2 cycles after acceptance. With ZERO_MODE=0, ZERO, POS and NEG(0x80000000) all give 0.
- LT(0xBF800000, 0x3F800000) → out_y=1. LE(0x00000000, 0x80000000) → 1. EQ of the same pair → 1. LT of the same pair → 0.
- LT(0x7FC00000, 0x3F800000) → out_y=0, out_nv=1, nv_sticky=1. nv_sticky stays 1 until flag_clr; flag_clr in the same cycle as another set leaves it 1.
- EQ(0x7F800001, 0x7F800001) → out_y=0, out_nv=1, out_class=0x100. CLASS(0xFF800000) → 0x001. CLASS(0x00000001) → 0x020.
- Backpressure: hold out_ready=0 and drive 3 back-to-back requests with tags 1, 2, 3 → two accepted, then in_ready=0. Raising out_ready delivers tags 1, 2, 3 in order, and outputs stay stable while stalled. Asserting rst mid-stall → out_valid=0 next cycle, no stale result afterward.
- EXP_W=11, MAN_W=52: NEG(0xBFF0000000000000) → 1. CLASS(0x0000000000000001) → 0x020. CLASS(0x7FF8000000000000) → 0x200.

Source files
------------

// File: rtl/fpred_if.sv
// Request/result bundle for the floating-point predicate/compare unit.
// master = the side that issues requests and consumes results,
// slave  = the predicate unit itself.
interface fpred_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic [2:0]   in_op;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [3:0]   in_tag;
  logic         out_valid;
  logic         out_ready;
  logic         out_y;
  logic [9:0]   out_class;
  logic         out_nv;
  logic [3:0]   out_tag;
  logic         nv_sticky;
  logic         flag_clr;

  modport master (
    output in_valid, in_op, in_a, in_b, in_tag, out_ready, flag_clr,
    input  in_ready, out_valid, out_y, out_class, out_nv, out_tag, nv_sticky
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_tag, out_ready, flag_clr,
    output in_ready, out_valid, out_y, out_class, out_nv, out_tag, nv_sticky
  );
endinterface

// File: rtl/fpred_pipe.sv
// Two-stage floating-point predicate / ordered-compare unit.
// S1 decodes both operands and compares magnitudes; S2 selects the result
// for the requested op and produces the invalid flag. S2 drives the outputs.
module fpred_pipe #(
  parameter int EXP_W     = 8,
  parameter int MAN_W     = 23,
  parameter int ZERO_MODE = 1
) (
  input  logic    clk,
  input  logic    rst,
  fpred_if.slave  bus
);
  localparam int W = 1 + EXP_W + MAN_W;

  localparam logic [2:0] OP_ZERO  = 3'd0;
  localparam logic [2:0] OP_POS   = 3'd1;
  localparam logic [2:0] OP_NEG   = 3'd2;
  localparam logic [2:0] OP_EQ    = 3'd3;
  localparam logic [2:0] OP_LT    = 3'd4;
  localparam logic [2:0] OP_LE    = 3'd5;
  localparam logic [2:0] OP_CLASS = 3'd6;

  // One-hot class: -inf,-norm,-sub,-0,+0,+sub,+norm,+inf,sNaN,qNaN (bit0..9)
  function automatic logic [9:0] classify(input logic [W-1:0] v);
    logic             s;
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] m;
    logic [9:0]       c;
    s = v[W-1];
    e = v[W-2 -: EXP_W];
    m = v[MAN_W-1:0];
    c = '0;
    if (&e) begin
      if (m == '0) begin
        if (s) c[0] = 1'b1; else c[7] = 1'b1;
      end else if (m[MAN_W-1]) begin
        c[9] = 1'b1;
      end else begin
        c[8] = 1'b1;
      end
    end else if (e == '0) begin
      if (m == '0) begin
        if (s) c[3] = 1'b1; else c[4] = 1'b1;
      end else begin
        if (s) c[2] = 1'b1; else c[5] = 1'b1;
      end
    end else begin
      if (s) c[1] = 1'b1; else c[6] = 1'b1;
    end
    return c;
  endfunction

  logic       adv1, adv2;
  logic       s1_valid, s2_valid;
  logic [2:0] s1_op;
  logic [3:0] s1_tag;
  logic [9:0] s1_cls_a;
  logic       s1_sa, s1_sb;
  logic       s1_b_zero, s1_b_nan, s1_b_snan;
  logic       s1_mlt, s1_meq;
  logic [9:0] cls_b;

  logic       s2_y, s2_nv;
  logic [9:0] s2_cls;
  logic [3:0] s2_tag;
  logic       sticky;

  logic       a_zero, a_nan, nan_any, snan_any, both_zero;
  logic       eq_o, lt_o, y_nxt, nv_nxt;

  // Stage advance: a stage moves when the stage after it can take its contents.
  assign adv2         = ~s2_valid | bus.out_ready;
  assign adv1         = ~s1_valid | adv2;
  assign bus.in_ready = adv1 & ~rst;
  assign cls_b        = classify(bus.in_b);

  // S1: capture decoded operands and magnitude compare on acceptance only.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_op     <= '0;
      s1_tag    <= '0;
      s1_cls_a  <= '0;
      s1_sa     <= 1'b0;
      s1_sb     <= 1'b0;
      s1_b_zero <= 1'b0;
      s1_b_nan  <= 1'b0;
      s1_b_snan <= 1'b0;
      s1_mlt    <= 1'b0;
      s1_meq    <= 1'b0;
    end else if (adv1) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_op     <= bus.in_op;
        s1_tag    <= bus.in_tag;
        s1_cls_a  <= classify(bus.in_a);
        s1_sa     <= bus.in_a[W-1];
        s1_sb     <= bus.in_b[W-1];
        s1_b_zero <= cls_b[3] | cls_b[4];
        s1_b_nan  <= cls_b[8] | cls_b[9];
        s1_b_snan <= cls_b[8];
        s1_mlt    <= bus.in_a[W-2:0] <  bus.in_b[W-2:0];
        s1_meq    <= bus.in_a[W-2:0] == bus.in_b[W-2:0];
      end
    end
  end

  // S2 result select: unary predicates, ordered compares and invalid flag.
  always_comb begin
    a_zero    = s1_cls_a[3] | s1_cls_a[4];
    a_nan     = s1_cls_a[8] | s1_cls_a[9];
    nan_any   = a_nan | s1_b_nan;
    snan_any  = s1_cls_a[8] | s1_b_snan;
    both_zero = a_zero & s1_b_zero;
    eq_o      = both_zero | ((s1_sa == s1_sb) & s1_meq);
    lt_o      = 1'b0;
    if (both_zero)        lt_o = 1'b0;
    else if (s1_sa != s1_sb) lt_o = s1_sa;
    else if (!s1_sa)      lt_o = s1_mlt;
    else                  lt_o = ~s1_mlt & ~s1_meq;
    y_nxt  = 1'b0;
    nv_nxt = 1'b0;
    case (s1_op)
      OP_ZERO:  y_nxt = (ZERO_MODE != 0) ? a_zero : s1_cls_a[4];
      OP_POS:   y_nxt = ~s1_sa & ~a_zero & ~a_nan;
      OP_NEG:   y_nxt = s1_sa & ~a_zero & ~a_nan;
      OP_EQ: begin
        y_nxt  = ~nan_any & eq_o;
        nv_nxt = snan_any;
      end
      OP_LT: begin
        y_nxt  = ~nan_any & lt_o;
        nv_nxt = nan_any;
      end
      OP_LE: begin
        y_nxt  = ~nan_any & (lt_o | eq_o);
        nv_nxt = nan_any;
      end
      OP_CLASS: y_nxt = 1'b0;
      default:  nv_nxt = 1'b1;
    endcase
  end

  // S2 output registers; hold while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_y     <= 1'b0;
      s2_nv    <= 1'b0;
      s2_cls   <= '0;
      s2_tag   <= '0;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_y   <= y_nxt;
        s2_nv  <= nv_nxt;
        s2_cls <= s1_cls_a;
        s2_tag <= s1_tag;
      end
    end
  end

  // Sticky invalid flag; a set in the same cycle as a clear wins.
  always_ff @(posedge clk) begin
    if (rst)                                   sticky <= 1'b0;
    else if (s2_valid & bus.out_ready & s2_nv) sticky <= 1'b1;
    else if (bus.flag_clr)                     sticky <= 1'b0;
  end

  assign bus.out_valid = s2_valid;
  assign bus.out_y     = s2_y;
  assign bus.out_nv    = s2_nv;
  assign bus.out_class = s2_cls;
  assign bus.out_tag   = s2_tag;
  assign bus.nv_sticky = sticky;
endmodule
